// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer of the 8-bit model CPU.
// Holds IR, phase flop, flags, decode strobes and a retire counter.
module instr_sequencer #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    bus_in,
    input  logic             ir_ld,
    input  logic             sm_en,
    input  logic             cf_en,
    input  logic             zf_en,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic [DW-1:0]    ir,
    output logic             sm,
    output logic             c,
    output logic             z,
    output logic             mova,
    output logic             movb,
    output logic             movc,
    output logic             add,
    output logic             sub,
    output logic             and1,
    output logic             not1,
    output logic             rsr,
    output logic             rsl,
    output logic             jmp,
    output logic             jz,
    output logic             jc,
    output logic             in1,
    output logic             out1,
    output logic             nop,
    output logic             halt,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    logic [3:0] opcode;

    assign opcode = ir[DW-1 -: 4];

    // Registered state: IR, phase, flags, retired-instruction count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir     <= '0;
            sm     <= 1'b0;
            c      <= 1'b0;
            z      <= 1'b0;
            icount <= '0;
        end else begin
            if (sm_en)
                sm <= ~sm;
            if (ir_ld)
                ir <= bus_in;
            if (cf_en)
                c <= alu_cf;
            if (zf_en)
                z <= alu_zf;
            if (sm && sm_en)
                icount <= icount + 1'b1;
        end
    end

    // One-hot decode of IR, only live in the execute phase
    always_comb begin
        mova = 1'b0;
        movb = 1'b0;
        movc = 1'b0;
        add  = 1'b0;
        sub  = 1'b0;
        and1 = 1'b0;
        not1 = 1'b0;
        rsr  = 1'b0;
        rsl  = 1'b0;
        jmp  = 1'b0;
        jz   = 1'b0;
        jc   = 1'b0;
        in1  = 1'b0;
        out1 = 1'b0;
        nop  = 1'b0;
        halt = 1'b0;
        if (sm) begin
            unique case (opcode)
                4'h1: add  = 1'b1;
                4'h2: sub  = 1'b1;
                4'h3: and1 = 1'b1;
                4'h4: not1 = 1'b1;
                4'h5: rsr  = 1'b1;
                4'h6: rsl  = 1'b1;
                4'h7: jmp  = 1'b1;
                4'h8: jz   = 1'b1;
                4'h9: jc   = 1'b1;
                4'hA: in1  = 1'b1;
                4'hB: out1 = 1'b1;
                4'hC: begin
                    if (ir[3:2] == 2'b11)
                        movb = 1'b1;
                    else if (ir[1:0] == 2'b11)
                        movc = 1'b1;
                    else
                        mova = 1'b1;
                end
                4'hF: halt = 1'b1;
                // nop plus the undefined 1101/1110 opcodes
                default: nop = 1'b1;
            endcase
        end
    end

    assign halted = sm & halt & ~sm_en;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Directed tests followed by randomized instruction streams.
module tb_instr_sequencer;

    localparam int CW = 4;

    localparam int MOVA = 15, MOVB = 14, MOVC = 13, ADD = 12;
    localparam int SUB = 11, AND1 = 10, NOT1 = 9, RSR = 8;
    localparam int RSL = 7, JMP = 6, JZ = 5, JC = 4;
    localparam int IN1 = 3, OUT1 = 2, NOP = 1, HALT = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] bus_in = '0;
    logic ir_ld = 1'b0, sm_en = 1'b0, cf_en = 1'b0, zf_en = 1'b0;
    logic alu_cf = 1'b0, alu_zf = 1'b0;
    logic [7:0] ir;
    logic sm, c, z, halted;
    logic mova, movb, movc, add, sub, and1, not1, rsr;
    logic rsl, jmp, jz, jc, in1, out1, nop, halt;
    logic [CW-1:0] icount;
    logic [15:0] strobes;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_ir;
    logic m_sm, m_c, m_z;
    int retired;

    instr_sequencer #(.DW(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
        .ir_ld(ir_ld), .sm_en(sm_en), .cf_en(cf_en), .zf_en(zf_en),
        .alu_cf(alu_cf), .alu_zf(alu_zf),
        .ir(ir), .sm(sm), .c(c), .z(z),
        .mova(mova), .movb(movb), .movc(movc), .add(add),
        .sub(sub), .and1(and1), .not1(not1), .rsr(rsr),
        .rsl(rsl), .jmp(jmp), .jz(jz), .jc(jc),
        .in1(in1), .out1(out1), .nop(nop), .halt(halt),
        .halted(halted), .icount(icount)
    );

    assign strobes = {mova, movb, movc, add, sub, and1, not1, rsr,
                      rsl, jmp, jz, jc, in1, out1, nop, halt};

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_dec(logic [7:0] i, logic s);
        logic [15:0] v;
        int k;
        v = '0;
        if (!s)
            return v;
        case (i[7:4])
            4'h0: k = NOP;
            4'h1: k = ADD;
            4'h2: k = SUB;
            4'h3: k = AND1;
            4'h4: k = NOT1;
            4'h5: k = RSR;
            4'h6: k = RSL;
            4'h7: k = JMP;
            4'h8: k = JZ;
            4'h9: k = JC;
            4'hA: k = IN1;
            4'hB: k = OUT1;
            4'hC: k = (i[3:2] == 2'b11) ? MOVB :
                      (i[1:0] == 2'b11) ? MOVC : MOVA;
            4'hF: k = HALT;
            default: k = NOP;
        endcase
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic hx;
        hx = m_sm && (m_ir[7:4] == 4'hF) && !sm_en;
        chk("ir", 32'(ir), 32'(m_ir));
        chk("sm", 32'(sm), 32'(m_sm));
        chk("c", 32'(c), 32'(m_c));
        chk("z", 32'(z), 32'(m_z));
        chk("icount", 32'(icount), 32'(retired % (1 << CW)));
        chk("strobes", 32'(strobes), 32'(exp_dec(m_ir, m_sm)));
        chk("onehot", $countones(strobes), 32'(m_sm));
        chk("halted", 32'(halted), 32'(hx));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_ir = '0;
            m_sm = 1'b0;
            m_c = 1'b0;
            m_z = 1'b0;
            retired = 0;
        end else begin
            if (m_sm && sm_en)
                retired++;
            if (sm_en)
                m_sm = !m_sm;
            if (ir_ld)
                m_ir = bus_in;
            if (cf_en)
                m_c = alu_cf;
            if (zf_en)
                m_z = alu_zf;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic fetch(logic [7:0] op);
        bus_in = op;
        ir_ld = 1'b1;
        sm_en = 1'b1;
        tick();
        ir_ld = 1'b0;
        bus_in = $urandom;
    endtask

    task automatic flags(logic ce, logic ze, logic ac, logic az);
        cf_en = ce;
        zf_en = ze;
        alu_cf = ac;
        alu_zf = az;
    endtask

    task automatic exec();
        sm_en = 1'b1;
        tick();
        flags(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] mv_ops [5];
    logic [7:0] op;
    int hold;

    initial begin
        m_ir = '0;
        m_sm = 1'b0;
        m_c = 1'b0;
        m_z = 1'b0;
        retired = 0;
        mv_ops = '{8'hCC, 8'hC3, 8'hC4, 8'hD0, 8'hE0};

        @(negedge clk);
        do_reset();
        chk("reset_sm", 32'(sm), 0);
        chk("reset_strobes", 32'(strobes), 0);

        // T2: add fetch then execute
        fetch(8'h15);
        chk("t2_add", 32'(add), 1);
        chk("t2_ir", 32'(ir), 32'h15);
        flags(1, 1, 1, 1);
        exec();
        chk("t2_icount", 32'(icount), 1);
        chk("t2_sm", 32'(sm), 0);

        // T1: reset mid-execute with flags set
        fetch(8'h15);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t1_ir", 32'(ir), 0);
        chk("t1_c", 32'(c), 0);
        chk("t1_z", 32'(z), 0);
        chk("t1_icount", 32'(icount), 0);
        chk("t1_strobes", 32'(strobes), 0);

        // T3: mov variants and undefined opcodes
        foreach (mv_ops[i]) begin
            fetch(mv_ops[i]);
            exec();
        end

        // T4: independent flag enables
        fetch(8'h10);
        flags(1, 0, 1, 1);
        exec();
        chk("t4_c", 32'(c), 1);
        chk("t4_z", 32'(z), 0);
        flags(0, 1, 0, 1);
        fetch(8'h20);
        flags(0, 0, 0, 0);
        exec();
        chk("t4_c2", 32'(c), 1);
        chk("t4_z2", 32'(z), 1);

        // T5: halt holds until reset
        fetch(8'hF0);
        sm_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_halted", 32'(halted), 1);
        end
        do_reset();
        chk("t5_recover", 32'(sm), 0);

        // T6: 16 nops wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            fetch(8'h0F);
            exec();
            if (i == 14)
                chk("t6_15", 32'(icount), 15);
        end
        chk("t6_wrap", 32'(icount), 0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            op = 8'($urandom);
            flags($urandom, $urandom, $urandom, $urandom);
            fetch(op);
            flags($urandom, $urandom, $urandom, $urandom);
            if (op[7:4] == 4'hF) begin
                sm_en = 1'b0;
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++)
                    tick();
                flags(0, 0, 0, 0);
                if ($urandom_range(0, 1) == 1)
                    do_reset();
                else begin
                    rst_n = 1'b0;
                    sm_en = 1'b1;
                    tick();
                    rst_n = 1'b1;
                end
            end else begin
                exec();
            end
            if ($urandom_range(0, 40) == 0)
                do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
